ddr5_phy_read_preamble_detect: RTL

- Read-direction counterpart of the PHY write DQS shifter.
- Monitors the 2-bit-per-clock sampled read DQS stream and finds the programmed read preamble, matching it with a sliding window.
- Frames the read burst data window (BL16/BL8), handles back-to-back reads (interamble) and the postamble, and flags missing or excess reads.
- Sits between the read DQS sampler and the read DQ deserializer/FIFO write control.

---
 rtl/ddr5_phy_read_preamble_detect.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ddr5_phy_read_preamble_detect.sv
// DDR5 PHY read preamble detector: matches the programmed read preamble on the
// sampled DQS stream, frames BL8/BL16 data windows, and tracks outstanding reads.
module ddr5_phy_read_preamble_detect #(
    parameter int unsigned PEND_W = 2,
    parameter int unsigned TMO_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_en_i,
    input  logic [1:0]       dqs_bits_i,
    input  logic [7:0]       pre_pattern_i,
    input  logic [2:0]       pre_cycles_i,
    input  logic             burst_eight_i,
    input  logic             post_cycles_i,
    input  logic [TMO_W-1:0] timeout_i,
    output logic             data_valid_o,
    output logic             burst_start_o,
    output logic             burst_done_o,
    output logic             timeout_err_o,
    output logic             overflow_err_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        DATA   = 3'd2,
        POST   = 3'd3
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state, state_nxt;
    logic [7:0]        window, window_nxt, mask;
    logic [PEND_W-1:0] pending, pend_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic [2:0]        data_cnt, data_cnt_nxt;
    logic              bl8, bl8_nxt;
    logic              post_two, post_two_nxt;
    logic              post_cnt, post_cnt_nxt;
    logic              match, sat, inc, dec, tmo_hit, data_last;
    logic              dv_nxt, start_nxt, done_nxt, tmo_err_nxt, ovf_nxt;

    // Preamble match, pending bookkeeping and state transitions
    always_comb begin
        window_nxt   = {window[5:0], dqs_bits_i};
        case (pre_cycles_i)
            3'd1:    mask = 8'h03;
            3'd2:    mask = 8'h0F;
            3'd3:    mask = 8'h3F;
            default: mask = 8'hFF;
        endcase
        match        = ((window_nxt ^ pre_pattern_i) & mask) == 8'h00;
        sat          = pending == PEND_MAX;
        inc          = rd_en_i && !sat;
        ovf_nxt      = rd_en_i && sat;
        tmo_hit      = tmo_cnt == timeout_i;
        dec          = (state == SEARCH) && (match || tmo_hit);
        pend_nxt     = pending + PEND_W'(inc) - PEND_W'(dec);
        data_last    = bl8 ? (data_cnt == 3'd3) : (data_cnt == 3'd7);

        state_nxt    = state;
        tmo_nxt      = '0;
        data_cnt_nxt = data_cnt;
        bl8_nxt      = bl8;
        post_two_nxt = post_two;
        post_cnt_nxt = post_cnt;
        start_nxt    = 1'b0;
        tmo_err_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (pending != '0 || rd_en_i) state_nxt = SEARCH;
            end
            SEARCH: begin
                if (match) begin
                    state_nxt    = DATA;
                    data_cnt_nxt = 3'd0;
                    bl8_nxt      = burst_eight_i;
                    start_nxt    = 1'b1;
                end else if (tmo_hit) begin
                    tmo_err_nxt = 1'b1;
                    if (pend_nxt == '0) state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            DATA: begin
                if (data_last) begin
                    // Interamble: a queued read skips the postamble entirely
                    if (pend_nxt != '0) begin
                        state_nxt = SEARCH;
                    end else begin
                        state_nxt    = POST;
                        post_cnt_nxt = 1'b0;
                        post_two_nxt = post_cycles_i;
                    end
                end else begin
                    data_cnt_nxt = data_cnt + 3'd1;
                end
            end
            POST: begin
                if (post_cnt == post_two) begin
                    state_nxt = (pend_nxt != '0) ? SEARCH : IDLE;
                end else begin
                    post_cnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        dv_nxt   = state_nxt == DATA;
        done_nxt = (state_nxt == DATA) &&
                   (bl8_nxt ? (data_cnt_nxt == 3'd3) : (data_cnt_nxt == 3'd7));
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            window         <= 8'h00;
            pending        <= '0;
            tmo_cnt        <= '0;
            data_cnt       <= 3'd0;
            bl8            <= 1'b0;
            post_two       <= 1'b0;
            post_cnt       <= 1'b0;
            data_valid_o   <= 1'b0;
            burst_start_o  <= 1'b0;
            burst_done_o   <= 1'b0;
            timeout_err_o  <= 1'b0;
            overflow_err_o <= 1'b0;
        end else begin
            state          <= state_nxt;
            window         <= window_nxt;
            pending        <= pend_nxt;
            tmo_cnt        <= tmo_nxt;
            data_cnt       <= data_cnt_nxt;
            bl8            <= bl8_nxt;
            post_two       <= post_two_nxt;
            post_cnt       <= post_cnt_nxt;
            data_valid_o   <= dv_nxt;
            burst_start_o  <= start_nxt;
            burst_done_o   <= done_nxt;
            timeout_err_o  <= tmo_err_nxt;
            overflow_err_o <= ovf_nxt;
        end
    end

    assign state_o = state;

endmodule
